// File: rtl/game_pkg.sv
// Shared game constants and types, imported by the screen sequencer and the drawing modules.
//   screen_e   : overlay selector encoding (START / PLAY / FINISH)
//   FINISH_*   : finish zone bounds (all exclusive) and the level they apply to
//   FRAMES_PER_SEC, START_DEBOUNCE_FRAMES : frame-based timing defaults
package game_pkg;

  typedef enum logic [1:0] {
    SCR_START  = 2'd0,
    SCR_PLAY   = 2'd1,
    SCR_FINISH = 2'd2
  } screen_e;

  localparam int unsigned FRAMES_PER_SEC        = 60;
  localparam int unsigned FINISH_X_LEFT         = 500;
  localparam int unsigned FINISH_X_RIGHT        = 700;
  localparam int unsigned FINISH_Y_UP           = 100;
  localparam int unsigned FINISH_Y_DOWN         = 112;
  localparam logic [1:0]  FINISH_LEVEL          = 2'b11;
  localparam int unsigned START_DEBOUNCE_FRAMES = 3;
  localparam logic [9:0]  ELAPSED_SEC_MAX       = 10'd1023;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator and per-frame button debouncer.
//   clk_i, rst_i : clock, synchronous active-high reset
//   vblnk_i      : vertical blank; a rising edge is one frame tick
//   btn_i        : synchronised button sampled once per frame tick
//   clr_i        : clears the debounce count (wins over the tick update)
//   tick_o       : one-cycle pulse on the vblnk rising edge
//   btn_ok_o     : button has been high for DEBOUNCE_FRAMES consecutive ticks,
//                  including the tick of the current cycle
module frame_tick_gen #(
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vblnk_i,
  input  logic btn_i,
  input  logic clr_i,
  output logic tick_o,
  output logic btn_ok_o
);

  localparam int unsigned    CntW   = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_FRAMES);

  logic            vblnk_q;
  logic            armed_q;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_upd;

  // armed_q stays low until vblnk has been seen low after reset, so a vblnk that is
  // already high when reset releases does not count as a frame edge.
  assign tick_o = vblnk_i & ~vblnk_q & armed_q;

  always_comb begin
    cnt_upd = cnt_q;
    if (tick_o) begin
      if (!btn_i) begin
        cnt_upd = '0;
      end else if (cnt_q != CntMax) begin
        cnt_upd = cnt_q + 1'b1;
      end
    end
    cnt_d = clr_i ? '0 : cnt_upd;
  end

  // Looks at the post-tick count so the deciding tick itself can start the game.
  assign btn_ok_o = (cnt_upd == CntMax);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vblnk_q <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      vblnk_q <= vblnk_i;
      if (!vblnk_i) begin
        armed_q <= 1'b1;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/screen_seq_ctrl.sv
// Frame-synchronous overlay sequencer: START -> PLAY -> FINISH -> START.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   vblnk_i             : vertical blank (rising edge = frame tick)
//   level_i             : current map level
//   x_value_i/y_value_i : player position, checked against the finish zone
//   start_btn_i         : debounced over START_DEBOUNCE_FRAMES ticks to leave START
//   restart_btn_i       : returns to START from PLAY/FINISH on any cycle
//   screen_sel_o        : 0 START, 1 PLAY, 2 FINISH
//   game_en_o           : high only in PLAY
//   level_rst_o         : one-cycle pulse when returning to START
//   elapsed_sec_o       : seconds in PLAY, saturating at 1023
//   frame_in_sec_o      : frame count within the current second
// Optional: SCREEN_SEQ_AUTO_RESTART_EN adds FINISH_HOLD_FRAMES, after which FINISH
// returns to START by itself.
module screen_seq_ctrl #(
  parameter int unsigned FRAMES_PER_SEC        = game_pkg::FRAMES_PER_SEC,
  parameter int unsigned FINISH_X_LEFT         = game_pkg::FINISH_X_LEFT,
  parameter int unsigned FINISH_X_RIGHT        = game_pkg::FINISH_X_RIGHT,
  parameter int unsigned FINISH_Y_UP           = game_pkg::FINISH_Y_UP,
  parameter int unsigned FINISH_Y_DOWN         = game_pkg::FINISH_Y_DOWN,
  parameter logic [1:0]  FINISH_LEVEL          = game_pkg::FINISH_LEVEL,
  parameter int unsigned START_DEBOUNCE_FRAMES = game_pkg::START_DEBOUNCE_FRAMES
`ifdef SCREEN_SEQ_AUTO_RESTART_EN
  , parameter int unsigned FINISH_HOLD_FRAMES  = 300
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        vblnk_i,
  input  logic [1:0]  level_i,
  input  logic [11:0] x_value_i,
  input  logic [11:0] y_value_i,
  input  logic        start_btn_i,
  input  logic        restart_btn_i,
  output logic [1:0]  screen_sel_o,
  output logic        game_en_o,
  output logic        level_rst_o,
  output logic [9:0]  elapsed_sec_o,
  output logic [5:0]  frame_in_sec_o
);

  import game_pkg::*;

  localparam logic [5:0] FrameLast = 6'(FRAMES_PER_SEC - 1);

  screen_e    state_q;
  logic       game_en_q;
  logic       level_rst_q;
  logic [9:0] elapsed_sec_q;
  logic [5:0] frame_in_sec_q;

  logic tick, start_ok, in_zone, restart, go_play, hold_done;

  frame_tick_gen #(
    .DEBOUNCE_FRAMES(START_DEBOUNCE_FRAMES)
  ) u_frame_tick_gen (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .vblnk_i (vblnk_i),
    .btn_i   (start_btn_i),
    .clr_i   (restart | go_play),
    .tick_o  (tick),
    .btn_ok_o(start_ok)
  );

  assign in_zone = (level_i == FINISH_LEVEL) &&
                   (32'(x_value_i) > FINISH_X_LEFT) && (32'(x_value_i) < FINISH_X_RIGHT) &&
                   (32'(y_value_i) > FINISH_Y_UP)   && (32'(y_value_i) < FINISH_Y_DOWN);

  assign restart = restart_btn_i && (state_q != SCR_START);
  assign go_play = (state_q == SCR_START) && tick && start_ok;

`ifdef SCREEN_SEQ_AUTO_RESTART_EN
  localparam int unsigned     HoldW    = $clog2(FINISH_HOLD_FRAMES + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(FINISH_HOLD_FRAMES - 1);

  logic [HoldW-1:0] hold_q;

  assign hold_done = (state_q == SCR_FINISH) && tick && (hold_q == HoldLast);

  // Counts ticks spent in FINISH; reloads to zero whenever FINISH is not the state.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != SCR_FINISH) begin
      hold_q <= '0;
    end else if (tick) begin
      hold_q <= hold_q + 1'b1;
    end
  end
`else
  assign hold_done = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= SCR_START;
      game_en_q      <= 1'b0;
      level_rst_q    <= 1'b0;
      elapsed_sec_q  <= '0;
      frame_in_sec_q <= '0;
    end else begin
      level_rst_q <= 1'b0;
      unique case (state_q)
        SCR_START: begin
          if (go_play) begin
            state_q        <= SCR_PLAY;
            game_en_q      <= 1'b1;
            elapsed_sec_q  <= '0;
            frame_in_sec_q <= '0;
          end
        end
        SCR_PLAY: begin
          if (restart) begin
            state_q     <= SCR_START;
            game_en_q   <= 1'b0;
            level_rst_q <= 1'b1;
          end else if (tick) begin
            if (in_zone) begin
              state_q   <= SCR_FINISH;
              game_en_q <= 1'b0;
            end
            // The finishing tick still advances the play timer.
            if (frame_in_sec_q == FrameLast) begin
              frame_in_sec_q <= '0;
              if (elapsed_sec_q != ELAPSED_SEC_MAX) begin
                elapsed_sec_q <= elapsed_sec_q + 1'b1;
              end
            end else begin
              frame_in_sec_q <= frame_in_sec_q + 1'b1;
            end
          end
        end
        SCR_FINISH: begin
          if (restart || hold_done) begin
            state_q     <= SCR_START;
            level_rst_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= SCR_START;
          game_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign screen_sel_o   = state_q;
  assign game_en_o      = game_en_q;
  assign level_rst_o    = level_rst_q;
  assign elapsed_sec_o  = elapsed_sec_q;
  assign frame_in_sec_o = frame_in_sec_q;

endmodule

// File: tb/tb_screen_seq_ctrl.sv
module tb_screen_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst2 = 1'b0;
  logic        vblnk = 1'b0;
  logic        start_btn = 1'b0;
  logic        restart_btn = 1'b0;
  logic [1:0]  level = 2'd0;
  logic [11:0] x_value = 12'd0;
  logic [11:0] y_value = 12'd0;

  logic [1:0]  screen_sel, sat_screen_sel;
  logic        game_en, sat_game_en;
  logic        level_rst, sat_level_rst;
  logic [9:0]  elapsed_sec, sat_elapsed_sec;
  logic [5:0]  frame_in_sec, sat_frame_in_sec;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  screen_seq_ctrl u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .vblnk_i       (vblnk),
    .level_i       (level),
    .x_value_i     (x_value),
    .y_value_i     (y_value),
    .start_btn_i   (start_btn),
    .restart_btn_i (restart_btn),
    .screen_sel_o  (screen_sel),
    .game_en_o     (game_en),
    .level_rst_o   (level_rst),
    .elapsed_sec_o (elapsed_sec),
    .frame_in_sec_o(frame_in_sec)
  );

  // Short seconds so saturation of elapsed_sec is reachable in a short run.
  screen_seq_ctrl #(
    .FRAMES_PER_SEC(2)
  ) u_dut_sat (
    .clk_i         (clk),
    .rst_i         (rst2),
    .vblnk_i       (vblnk),
    .level_i       (2'd0),
    .x_value_i     (12'd0),
    .y_value_i     (12'd0),
    .start_btn_i   (start_btn),
    .restart_btn_i (1'b0),
    .screen_sel_o  (sat_screen_sel),
    .game_en_o     (sat_game_en),
    .level_rst_o   (sat_level_rst),
    .elapsed_sec_o (sat_elapsed_sec),
    .frame_in_sec_o(sat_frame_in_sec)
  );

  // Returns on the falling edge after the tick edge, so the tick's results are visible.
  task automatic do_tick();
    @(negedge clk) vblnk = 1'b1;
    @(negedge clk) vblnk = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;
    n_checks++;
    if (screen_sel !== 2'd0) $display("FAIL reset_screen_sel got %0d want 0", screen_sel);
    else n_pass++;
    n_checks++;
    if (game_en !== 1'b0) $display("FAIL reset_game_en got %0b want 0", game_en);
    else n_pass++;
    n_checks++;
    if (level_rst !== 1'b0) $display("FAIL reset_level_rst got %0b want 0", level_rst);
    else n_pass++;
    n_checks++;
    if (elapsed_sec !== 10'd0) $display("FAIL reset_elapsed got %0d want 0", elapsed_sec);
    else n_pass++;
    n_checks++;
    if (frame_in_sec !== 6'd0) $display("FAIL reset_frame got %0d want 0", frame_in_sec);
    else n_pass++;
  endtask

  task automatic test_debounce();
    // Restart in START does nothing.
    @(negedge clk) restart_btn = 1'b1;
    @(negedge clk) restart_btn = 1'b0;
    n_checks++;
    if (level_rst !== 1'b0 || screen_sel !== 2'd0)
      $display("FAIL restart_in_start got sel=%0d lrst=%0b want sel=0 lrst=0", screen_sel, level_rst);
    else n_pass++;
    start_btn = 1'b1;
    do_ticks(2);
    n_checks++;
    if (screen_sel !== 2'd0) $display("FAIL debounce_2_ticks got %0d want 0", screen_sel);
    else n_pass++;
    start_btn = 1'b0;
    do_tick();
    start_btn = 1'b1;
    do_ticks(2);
    n_checks++;
    if (screen_sel !== 2'd0) $display("FAIL debounce_cleared got %0d want 0", screen_sel);
    else n_pass++;
    // Third held tick, with restart asserted at the same time: START -> PLAY anyway.
    @(negedge clk) begin vblnk = 1'b1; restart_btn = 1'b1; end
    @(negedge clk) begin vblnk = 1'b0; restart_btn = 1'b0; end
    start_btn = 1'b0;
    n_checks++;
    if (screen_sel !== 2'd1) $display("FAIL debounce_3_ticks got %0d want 1", screen_sel);
    else n_pass++;
    n_checks++;
    if (game_en !== 1'b1) $display("FAIL play_game_en got %0b want 1", game_en);
    else n_pass++;
    n_checks++;
    if (level_rst !== 1'b0) $display("FAIL start_restart_lrst got %0b want 0", level_rst);
    else n_pass++;
    n_checks++;
    if (elapsed_sec !== 10'd0 || frame_in_sec !== 6'd0)
      $display("FAIL play_entry_counters got %0d/%0d want 0/0", elapsed_sec, frame_in_sec);
    else n_pass++;
  endtask

  task automatic test_counters();
    do_ticks(125);
    n_checks++;
    if (elapsed_sec !== 10'd2) $display("FAIL elapsed_125 got %0d want 2", elapsed_sec);
    else n_pass++;
    n_checks++;
    if (frame_in_sec !== 6'd5) $display("FAIL frame_125 got %0d want 5", frame_in_sec);
    else n_pass++;
  endtask

  task automatic test_finish_zone();
    level = 2'd3; x_value = 12'd500; y_value = 12'd105;
    do_tick();
    n_checks++;
    if (screen_sel !== 2'd1) $display("FAIL zone_x_500 got %0d want 1", screen_sel);
    else n_pass++;
    x_value = 12'd600; y_value = 12'd112;
    do_tick();
    n_checks++;
    if (screen_sel !== 2'd1) $display("FAIL zone_y_112 got %0d want 1", screen_sel);
    else n_pass++;
    level = 2'd2; y_value = 12'd105;
    do_tick();
    n_checks++;
    if (screen_sel !== 2'd1) $display("FAIL zone_level_2 got %0d want 1", screen_sel);
    else n_pass++;
    // Inside the zone between ticks: no change until the next tick.
    @(negedge clk) level = 2'd3;
    repeat (4) @(negedge clk);
    n_checks++;
    if (screen_sel !== 2'd1) $display("FAIL zone_between_ticks got %0d want 1", screen_sel);
    else n_pass++;
    do_tick();
    n_checks++;
    if (screen_sel !== 2'd2 || game_en !== 1'b0)
      $display("FAIL zone_finish got sel=%0d en=%0b want sel=2 en=0", screen_sel, game_en);
    else n_pass++;
    // 125 + 4 ticks: the finishing tick still counts.
    n_checks++;
    if (elapsed_sec !== 10'd2 || frame_in_sec !== 6'd9)
      $display("FAIL finish_tick_counts got %0d/%0d want 2/9", elapsed_sec, frame_in_sec);
    else n_pass++;
  endtask

  task automatic test_frozen();
    do_ticks(200);
    n_checks++;
    if (screen_sel !== 2'd2) $display("FAIL frozen_state got %0d want 2", screen_sel);
    else n_pass++;
    n_checks++;
    if (elapsed_sec !== 10'd2 || frame_in_sec !== 6'd9)
      $display("FAIL frozen_counts got %0d/%0d want 2/9", elapsed_sec, frame_in_sec);
    else n_pass++;
  endtask

  task automatic test_restart();
    @(negedge clk) restart_btn = 1'b1;
    @(negedge clk) restart_btn = 1'b0;
    n_checks++;
    if (screen_sel !== 2'd0 || level_rst !== 1'b1)
      $display("FAIL restart_edge got sel=%0d lrst=%0b want sel=0 lrst=1", screen_sel, level_rst);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (level_rst !== 1'b0) $display("FAIL restart_pulse_len got %0b want 0", level_rst);
    else n_pass++;
  endtask

  task automatic enter_play();
    level = 2'd0;
    start_btn = 1'b1;
    do_ticks(3);
    start_btn = 1'b0;
  endtask

  task automatic test_restart_vs_finish();
    enter_play();
    n_checks++;
    if (screen_sel !== 2'd1 || elapsed_sec !== 10'd0 || frame_in_sec !== 6'd0)
      $display("FAIL replay_entry got sel=%0d %0d/%0d want 1 0/0", screen_sel, elapsed_sec,
               frame_in_sec);
    else n_pass++;
    level = 2'd3; x_value = 12'd600; y_value = 12'd105;
    @(negedge clk) begin vblnk = 1'b1; restart_btn = 1'b1; end
    @(negedge clk) begin vblnk = 1'b0; restart_btn = 1'b0; end
    n_checks++;
    if (screen_sel !== 2'd0 || level_rst !== 1'b1)
      $display("FAIL restart_beats_finish got sel=%0d lrst=%0b want sel=0 lrst=1", screen_sel,
               level_rst);
    else n_pass++;
  endtask

  task automatic test_hold();
    enter_play();
    level = 2'd3;
    do_tick();
    n_checks++;
    if (screen_sel !== 2'd2) $display("FAIL hold_enter_finish got %0d want 2", screen_sel);
    else n_pass++;
`ifdef SCREEN_SEQ_AUTO_RESTART_EN
    do_ticks(299);
    n_checks++;
    if (screen_sel !== 2'd2) $display("FAIL hold_299 got %0d want 2", screen_sel);
    else n_pass++;
    do_tick();
    n_checks++;
    if (screen_sel !== 2'd0 || level_rst !== 1'b1)
      $display("FAIL hold_300 got sel=%0d lrst=%0b want sel=0 lrst=1", screen_sel, level_rst);
    else n_pass++;
`else
    do_ticks(1000);
    n_checks++;
    if (screen_sel !== 2'd2 || level_rst !== 1'b0)
      $display("FAIL hold_1000 got sel=%0d lrst=%0b want sel=2 lrst=0", screen_sel, level_rst);
    else n_pass++;
`endif
  endtask

  task automatic test_rst_mid_frame();
    level = 2'd0;
    @(negedge clk) begin vblnk = 1'b1; rst = 1'b1; end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_btn = 1'b1;
    n_checks++;
    if (screen_sel !== 2'd0 || elapsed_sec !== 10'd0 || game_en !== 1'b0)
      $display("FAIL midrst_state got sel=%0d sec=%0d en=%0b want 0/0/0", screen_sel, elapsed_sec,
               game_en);
    else n_pass++;
    repeat (3) @(negedge clk);
    vblnk = 1'b0;
    @(negedge clk);
    // vblnk high at release must not count, so two real ticks are not enough.
    do_ticks(2);
    n_checks++;
    if (screen_sel !== 2'd0) $display("FAIL midrst_no_tick got %0d want 0", screen_sel);
    else n_pass++;
    do_tick();
    start_btn = 1'b0;
    n_checks++;
    if (screen_sel !== 2'd1) $display("FAIL midrst_third_tick got %0d want 1", screen_sel);
    else n_pass++;
  endtask

  task automatic test_saturate();
    do_ticks(2100);
    n_checks++;
    if (elapsed_sec !== 10'd35 || frame_in_sec !== 6'd0)
      $display("FAIL long_play got %0d/%0d want 35/0", elapsed_sec, frame_in_sec);
    else n_pass++;
    n_checks++;
    if (sat_screen_sel !== 2'd1) $display("FAIL sat_state got %0d want 1", sat_screen_sel);
    else n_pass++;
    n_checks++;
    if (sat_elapsed_sec !== 10'd1023)
      $display("FAIL sat_elapsed got %0d want 1023", sat_elapsed_sec);
    else n_pass++;
    do_ticks(4);
    n_checks++;
    if (sat_elapsed_sec !== 10'd1023)
      $display("FAIL sat_hold got %0d want 1023", sat_elapsed_sec);
    else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout n_checks=%0d n_pass=%0d", n_checks, n_pass);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_debounce();
    test_counters();
    test_finish_zone();
    test_frozen();
    test_restart();
    test_restart_vs_finish();
    test_hold();
    test_rst_mid_frame();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
